// File: rtl/go_pulse_gen_if.sv
// -----------------------------------------------------------------------------
// go_pulse_gen_if
// Groups the push-button input and the strobe/status outputs of go_pulse_gen.
//
// Signals
//   btn_in     raw push-button (asynchronous, active-high, may bounce)
//   go         one-cycle advance strobe
//   btn_level  debounced button level
//   busy       high while the button FSM is outside IDLE
//
// Modports
//   slave   : the go_pulse_gen block (samples btn_in, drives the outputs)
//   master  : the board side / controller (drives btn_in, observes the outputs)
// -----------------------------------------------------------------------------
interface go_pulse_gen_if;
   logic btn_in;
   logic go;
   logic btn_level;
   logic busy;

   modport slave (
      input  btn_in,
      output go,
      output btn_level,
      output busy
   );

   modport master (
      output btn_in,
      input  go,
      input  btn_level,
      input  busy
   );
endinterface

// File: rtl/go_pulse_gen.sv
// -----------------------------------------------------------------------------
// go_pulse_gen
// Turns the raw board push-button into the single-cycle `go` strobe that
// advances the expression sequence. The button is synchronised (2 FF),
// debounced on both press and release, one-shot on the press and followed by
// a hold-off after release, so each physical press yields exactly one `go`
// and an LCD frame in progress is not cut short.
//
// Optional feature (macro AUTO_ADVANCE_EN): when defined, an idle counter
// issues an automatic `go` after AUTO_CYCLES idle cycles in IDLE. When not
// defined, no idle counter is built and AUTO_CYCLES is unused.
//
// Parameters
//   DEBOUNCE_CYCLES  stable samples needed to accept a press/release (>=2)
//   HOLDOFF_CYCLES   dead time after an accepted release (>=1)
//   AUTO_CYCLES      idle cycles before an automatic go (>=2)
//   CNT_W            counter width, must hold max(all of the above)-1
//
// Ports
//   clk   system clock
//   rst   synchronous, active-high reset
//   bus   go_pulse_gen_if.slave : btn_in in, go / btn_level / busy out
// -----------------------------------------------------------------------------
module go_pulse_gen #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int HOLDOFF_CYCLES  = 5_000_000,
   parameter int AUTO_CYCLES     = 500_000_000,
   parameter int CNT_W           = 32
) (
   input  logic          clk,
   input  logic          rst,
   go_pulse_gen_if.slave bus
);

   // Elaboration-time range check on the timing parameters.
   if (DEBOUNCE_CYCLES < 2 || HOLDOFF_CYCLES < 1 || AUTO_CYCLES < 2) begin : g_param_check
      $fatal(1, "go_pulse_gen: timing parameter out of range");
   end

   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HO_LAST = CNT_W'(HOLDOFF_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DB_PRESS,
      ST_PRESSED,
      ST_DB_RELEASE,
      ST_HOLDOFF
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              sync1_q, sync1_d;
   logic              sync2_q, sync2_d;
   logic              go_q, go_d;
   logic              btn_level_q, btn_level_d;
   logic              busy_q, busy_d;
   logic              go_press;
   logic              go_auto;

   // Two-flop synchroniser; only sync2_q is seen by the FSM.
   always_comb begin
      sync1_d = bus.btn_in;
      sync2_d = sync1_q;
   end

   // Button FSM: next state, counter and press strobe.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      go_press = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (sync2_q) begin
               state_d = ST_DB_PRESS;
               cnt_d   = CNT_W'(1);
            end
         end
         ST_DB_PRESS: begin
            if (!sync2_q) begin
               // Bounce: back to IDLE without a strobe.
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == DB_LAST) begin
               state_d  = ST_PRESSED;
               cnt_d    = '0;
               go_press = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_PRESSED: begin
            cnt_d = '0;
            if (!sync2_q) begin
               state_d = ST_DB_RELEASE;
               cnt_d   = CNT_W'(1);
            end
         end
         ST_DB_RELEASE: begin
            if (sync2_q) begin
               // Release bounced; still pressed, no new strobe.
               state_d = ST_PRESSED;
               cnt_d   = '0;
            end else if (cnt_q == DB_LAST) begin
               state_d = ST_HOLDOFF;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_HOLDOFF: begin
            // Button ignored entirely while the hold-off runs.
            if (cnt_q == HO_LAST) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

`ifdef AUTO_ADVANCE_EN
   localparam logic [CNT_W-1:0] AUTO_LAST = CNT_W'(AUTO_CYCLES - 1);

   logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;

   // Idle auto-advance: counts only while IDLE with the button released;
   // anything else clears the count. Auto and press strobes cannot both fire
   // on one edge (auto needs IDLE, press needs DB_PRESS), so go stays single.
   always_comb begin
      idle_cnt_d = '0;
      go_auto    = 1'b0;
      if (state_q == ST_IDLE && !sync2_q) begin
         if (idle_cnt_q == AUTO_LAST) begin
            go_auto = 1'b1;
         end else begin
            idle_cnt_d = idle_cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idle_cnt_q <= '0;
      end else begin
         idle_cnt_q <= idle_cnt_d;
      end
   end
`else
   assign go_auto = 1'b0;
`endif

   // Registered outputs, derived from the state being entered.
   always_comb begin
      go_d        = go_press | go_auto;
      btn_level_d = (state_d == ST_PRESSED) || (state_d == ST_DB_RELEASE);
      busy_d      = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         go_q        <= 1'b0;
         btn_level_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         go_q        <= go_d;
         btn_level_q <= btn_level_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.go        = go_q;
   assign bus.btn_level = btn_level_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_go_pulse_gen.sv
// -----------------------------------------------------------------------------
// tb_go_pulse_gen
// Scoreboard bench for go_pulse_gen (DEBOUNCE=4, HOLDOFF=8, AUTO=50, CNT_W=8).
// Stimulus pushes the edge number at which each go is expected; a monitor on
// the falling edge pops and compares whenever go is high. Edge n is the n-th
// rising clock edge; after it, at the following falling edge, cyc == n.
// -----------------------------------------------------------------------------
module tb_go_pulse_gen;

   localparam int D = 4;
   localparam int H = 8;
   localparam int A = 50;

   logic clk;
   logic rst;
   int   cyc;
   int   n_cmp;
   int   n_err;
   int   go_seen;
   int   exp_q[$];

   go_pulse_gen_if bus_if ();

   go_pulse_gen #(
      .DEBOUNCE_CYCLES (D),
      .HOLDOFF_CYCLES  (H),
      .AUTO_CYCLES     (A),
      .CNT_W           (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, act, exp, cyc);
      end
   endtask

   // Scoreboard monitor: every go must match the oldest expected edge.
   always @(negedge clk) begin
      if (bus_if.go === 1'b1) begin
         go_seen++;
         if (exp_q.size() == 0) begin
            chk("go_unexpected_at", cyc, 0);
         end else begin
            chk("go_edge", cyc, exp_q.pop_front());
         end
      end
   end

   task automatic wait_until(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   task automatic do_reset(output int e);
      exp_q.delete();
      @(negedge clk);
      rst = 1'b1;
      bus_if.btn_in = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      e = cyc;
   endtask

   task automatic end_test(input string tag, input int g0, input int n_go);
      chk({tag, "_go_count"}, go_seen - g0, n_go);
      chk({tag, "_pending"}, exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      int e, k, r, h, k3, r3, g, g0;
      n_cmp = 0;
      n_err = 0;
      go_seen = 0;
      rst = 1'b1;
      bus_if.btn_in = 1'b0;

      // Test 1: reset 3 edges, press sampled at edge 10, held 40 cycles.
      wait_until(3);
      chk("rst_go", bus_if.go, 0);
      chk("rst_busy", bus_if.busy, 0);
      chk("rst_level", bus_if.btn_level, 0);
      rst = 1'b0;
      g0 = go_seen;
      wait_until(9);
      bus_if.btn_in = 1'b1;
      k = 10;
      exp_q.push_back(k + D + 1);
      wait_until(11); chk("t1_busy_e11", bus_if.busy, 0);
      wait_until(12); chk("t1_busy_e12", bus_if.busy, 1);
      wait_until(14); chk("t1_level_e14", bus_if.btn_level, 0);
      wait_until(15); chk("t1_level_e15", bus_if.btn_level, 1);
      wait_until(k + 40 - 1);
      bus_if.btn_in = 1'b0;
      r = k + 40;
      wait_until(r + D);         chk("t1_level_rel", bus_if.btn_level, 1);
      wait_until(r + D + 1);     chk("t1_level_hold", bus_if.btn_level, 0);
      wait_until(r + D + H);     chk("t1_busy_hold", bus_if.busy, 1);
      wait_until(r + D + H + 1); chk("t1_busy_idle", bus_if.busy, 0);
      wait_until(r + D + H + 8);
      end_test("t1", g0, 1);

      // Test 2: bounce 1,0,1,0 gives no go and returns to IDLE.
      do_reset(e);
      g0 = go_seen;
      k = e + 3;
      wait_until(k - 1);
      bus_if.btn_in = 1'b1; @(negedge clk);
      bus_if.btn_in = 1'b0; @(negedge clk);
      bus_if.btn_in = 1'b1; @(negedge clk);
      bus_if.btn_in = 1'b0;
      wait_until(k + 4); chk("t2_busy_bounce", bus_if.busy, 1);
      wait_until(k + 5); chk("t2_busy_idle", bus_if.busy, 0);
      chk("t2_level", bus_if.btn_level, 0);
      wait_until(k + 20);
      end_test("t2", g0, 0);

      // Test 3: second press inside hold-off is ignored; third after IDLE counts.
      do_reset(e);
      g0 = go_seen;
      k = e + 3;
      wait_until(k - 1);
      bus_if.btn_in = 1'b1;
      exp_q.push_back(k + D + 1);
      wait_until(k + 5);
      bus_if.btn_in = 1'b0;
      r = k + 6;
      h = r + D + 1;
      wait_until(h + 4);
      bus_if.btn_in = 1'b1;
      wait_until(h + 6);
      bus_if.btn_in = 1'b0;
      wait_until(h + 7); chk("t3_busy_hold", bus_if.busy, 1);
      wait_until(h + 9); chk("t3_busy_idle", bus_if.busy, 0);
      k3 = h + 12;
      wait_until(k3 - 1);
      bus_if.btn_in = 1'b1;
      exp_q.push_back(k3 + D + 1);
      wait_until(k3 + 5);
      bus_if.btn_in = 1'b0;
      r3 = k3 + 6;
      wait_until(r3 + D + 1 + H + 2);
      end_test("t3", g0, 2);

      // Test 4: reset one cycle after go with the button still held.
      do_reset(e);
      g0 = go_seen;
      k = e + 3;
      wait_until(k - 1);
      bus_if.btn_in = 1'b1;
      g = k + D + 1;
      exp_q.push_back(g);
      wait_until(g);
      rst = 1'b1;
      wait_until(g + 1);
      chk("t4_rst_go", bus_if.go, 0);
      chk("t4_rst_busy", bus_if.busy, 0);
      chk("t4_rst_level", bus_if.btn_level, 0);
      wait_until(g + 2);
      rst = 1'b0;
      exp_q.push_back(g + 2 + D + 2);
      wait_until(g + 2 + D + 5);
      chk("t4_level_held", bus_if.btn_level, 1);
      bus_if.btn_in = 1'b0;
      r = cyc + 1;
      wait_until(r + D + 1 + H + 2);
      chk("t4_busy_end", bus_if.busy, 0);
      end_test("t4", g0, 2);

`ifdef AUTO_ADVANCE_EN
      // Test 5: idle auto-advance every A idle cycles; a bounce restarts it.
      do_reset(e);
      g0 = go_seen;
      exp_q.push_back(e + A);
      exp_q.push_back(e + 2 * A);
      exp_q.push_back(e + 3 * A);
      wait_until(e + 160);
      end_test("t5a", g0, 3);
      do_reset(e);
      g0 = go_seen;
      wait_until(e + 29);
      bus_if.btn_in = 1'b1;
      @(negedge clk);
      bus_if.btn_in = 1'b0;
      exp_q.push_back(e + 33 + A);
      wait_until(e + 33 + A + 5);
      end_test("t5b", g0, 1);
`else
      // Test 6: without auto-advance, an idle button never produces go.
      do_reset(e);
      g0 = go_seen;
      wait_until(e + 200);
      chk("t6_busy", bus_if.busy, 0);
      end_test("t6", g0, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
